// File: rtl/ifu_if.sv
// Instruction fetch unit bus: redirect controls, preload port and fetch/decode outputs.
interface ifu_if;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        jr;
  logic [31:0] jr_addr;
  logic        im_we;
  logic [9:0]  im_waddr;
  logic [31:0] im_wdata;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [25:0] instr_index;

  modport master (
    output stall, branch, jump, jr, jr_addr, im_we, im_waddr, im_wdata,
    input  pc, pc_plus4, instr, imm16, op, rs, rt, rd, shamt, funct, instr_index
  );

  modport slave (
    input  stall, branch, jump, jr, jr_addr, im_we, im_waddr, im_wdata,
    output pc, pc_plus4, instr, imm16, op, rs, rt, rd, shamt, funct, instr_index
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: PC register with stall/jr/jump/branch redirect and a
// preloadable word-addressed instruction memory read combinationally at pc.
module ifu #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 1024
) (
  input logic   clk,
  input logic   rst_n,
  ifu_if.slave  bus
);

  localparam int unsigned IDX_W = 10;

  logic [31:0]      pc_q;
  logic [31:0]      pc_next;
  logic [31:0]      pc_plus4;
  logic [31:0]      instr;
  logic [31:0]      br_target;
  logic [31:0]      jmp_target;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      im [IM_DEPTH];

  // Preload port; deliberately unaffected by reset or stall.
  always_ff @(posedge clk) begin
    if (bus.im_we) begin
      im[bus.im_waddr] <= bus.im_wdata;
    end
  end

  assign rd_idx     = pc_q[11:2];
  assign instr      = im[rd_idx];
  assign pc_plus4   = pc_q + 32'd4;
  assign br_target  = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Redirect priority: stall > jr > jump > branch > sequential.
  always_comb begin
    pc_next = pc_plus4;
    if (bus.stall) begin
      pc_next = pc_q;
    end else if (bus.jr) begin
      pc_next = bus.jr_addr;
    end else if (bus.jump) begin
      pc_next = jmp_target;
    end else if (bus.branch) begin
      pc_next = br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr       = instr;
  assign bus.imm16       = instr[15:0];
  assign bus.op          = instr[31:26];
  assign bus.rs          = instr[25:21];
  assign bus.rt          = instr[20:16];
  assign bus.rd          = instr[15:11];
  assign bus.shamt       = instr[10:6];
  assign bus.funct       = instr[5:0];
  assign bus.instr_index = instr[25:0];

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios with literal expectations plus a
// per-cycle comparison against an abstract next-PC / memory model.
module tb_ifu;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ifu_if bus ();

  ifu #(.PC_RESET(PC_RESET), .IM_DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mpc = PC_RESET;
  logic [31:0] mmem [1024];
  bit          mknown [1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pattern(input int i);
    case (i)
      0:       return 32'h1000_FFFE;
      1:       return 32'h0800_0C10;
      1023:    return 32'hDEAD_BEEF;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  // Next PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic st, input logic j_r,
                                             input logic [31:0] ja, input logic jm,
                                             input logic br);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(w[15:0])) * 4;
    if (st)       return pc;
    else if (j_r) return ja;
    else if (jm)  return {seq[31:28], w[25:0], 2'b00};
    else if (br)  return seq + 32'(off);
    else          return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mpc = PC_RESET;
    end else begin
      mpc = model_next(mpc, mmem[mpc[11:2]], bus.stall, bus.jr, bus.jr_addr,
                       bus.jump, bus.branch);
    end
  end

  always @(posedge clk) begin
    if (bus.im_we) begin
      mmem[bus.im_waddr]   <= bus.im_wdata;
      mknown[bus.im_waddr] <= 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] w;
    chk("pc", bus.pc, mpc);
    chk("pc_plus4", bus.pc_plus4, mpc + 32'd4);
    if (mknown[mpc[11:2]]) begin
      w = mmem[mpc[11:2]];
      chk("instr", bus.instr, w);
      chk("imm16", 32'(bus.imm16), 32'(w[15:0]));
      chk("op", 32'(bus.op), 32'(w[31:26]));
      chk("rs", 32'(bus.rs), 32'(w[25:21]));
      chk("rt", 32'(bus.rt), 32'(w[20:16]));
      chk("rd", 32'(bus.rd), 32'(w[15:11]));
      chk("shamt", 32'(bus.shamt), 32'(w[10:6]));
      chk("funct", 32'(bus.funct), 32'(w[5:0]));
      chk("instr_index", 32'(bus.instr_index), 32'(w[25:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall  = 1'b0;
    bus.branch = 1'b0;
    bus.jump   = 1'b0;
    bus.jr     = 1'b0;
  endtask

  initial begin
    clear_ctl();
    bus.jr_addr  = '0;
    bus.im_we    = 1'b0;
    bus.im_waddr = '0;
    bus.im_wdata = '0;

    // Preload the whole memory while reset is held.
    #1;
    for (int i = 0; i < 1024; i++) begin
      bus.im_we    = 1'b1;
      bus.im_waddr = 10'(i);
      bus.im_wdata = pattern(i);
      step();
    end
    bus.im_we = 1'b0;

    chk("rst_pc", bus.pc, 32'h0000_3000);
    chk("rst_pc4", bus.pc_plus4, 32'h0000_3004);
    chk("rst_instr", bus.instr, 32'h1000_FFFE);

    // Sequential fetch after release.
    rst_n = 1'b1;
    step(); step(); step();
    chk("seq3_pc", bus.pc, 32'h0000_300C);

    // Async reset between edges, then negative branch with index wrap.
    rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, 32'h0000_3000);
    rst_n = 1'b1;
    bus.branch = 1'b1;
    step();
    bus.branch = 1'b0;
    chk("nbr_pc", bus.pc, 32'h0000_2FFC);
    chk("nbr_instr_wrap", bus.instr, 32'hDEAD_BEEF);

    // Jump from 0x3004.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    chk("j_pc", bus.pc, 32'h0000_3004);
    chk("j_imm16", 32'(bus.imm16), 32'h0000_0C10);
    bus.jump = 1'b1;
    step();
    bus.jump = 1'b0;
    chk("j_target", bus.pc, 32'h0000_3040);

    // Reset does not disturb memory contents.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async2_pc", bus.pc, 32'h0000_3000);
    chk("async2_pc4", bus.pc_plus4, 32'h0000_3004);
    rst_n = 1'b1;
    step();
    chk("mem_kept", bus.instr, 32'h0800_0C10);

    // Priority: jr wins over jump/branch, stall wins over all.
    bus.jr      = 1'b1;
    bus.jr_addr = 32'h0000_3100;
    bus.jump    = 1'b1;
    bus.branch  = 1'b1;
    step();
    chk("prio_jr", bus.pc, 32'h0000_3100);
    bus.stall = 1'b1;
    step(); step();
    chk("prio_stall_pc", bus.pc, 32'h0000_3100);
    chk("prio_stall_instr", bus.instr, 32'hA500_0040);
    clear_ctl();

    // Write/read hazard on the word being fetched.
    bus.jr      = 1'b1;
    bus.jr_addr = 32'h0000_3008;
    step();
    bus.jr       = 1'b0;
    bus.stall    = 1'b1;
    bus.im_we    = 1'b1;
    bus.im_waddr = 10'd2;
    bus.im_wdata = 32'h3C01_1234;
    #2;
    chk("haz_old", bus.instr, 32'hA500_0002);
    step();
    bus.im_we = 1'b0;
    chk("haz_new", bus.instr, 32'h3C01_1234);
    chk("haz_imm16", 32'(bus.imm16), 32'h0000_1234);
    chk("haz_pc", bus.pc, 32'h0000_3008);
    bus.stall = 1'b0;

    // Unaligned jr target kept as-is; pc_plus4 and branch wrap at 2^32.
    bus.jr      = 1'b1;
    bus.jr_addr = 32'h0000_3101;
    step();
    chk("jr_unaligned", bus.pc, 32'h0000_3101);
    chk("jr_unaligned_instr", bus.instr, 32'hA500_0040);
    bus.jr_addr = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc4", bus.pc_plus4, 32'h0000_0000);
    bus.jr = 1'b0;
    step();
    chk("wrap_pc", bus.pc, 32'h0000_0000);
    bus.branch = 1'b1;
    step();
    bus.branch = 1'b0;
    chk("br_wrap", bus.pc, 32'hFFFF_FFFC);

    // Mixed traffic checked cycle by cycle against the model.
    for (int c = 0; c < 300; c++) begin
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.jr       = ($urandom_range(0, 7) == 0);
      bus.jump     = ($urandom_range(0, 7) == 0);
      bus.branch   = ($urandom_range(0, 7) == 0);
      bus.jr_addr  = $urandom();
      bus.im_we    = ($urandom_range(0, 3) == 0);
      bus.im_waddr = 10'($urandom_range(0, 1023));
      bus.im_wdata = $urandom();
      if ($urandom_range(0, 31) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end
    clear_ctl();
    bus.im_we = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
